// File: rtl/adc_axis_capture.sv
// ADC capture block: AXI-Stream slave into a pop-read FIFO with overflow and min/max tracking.
// Build option ADC_CAP_STATS_EN enables the min/max trackers; without it o_min/o_max read 0.

// Purpose: generic single-clock FIFO, occupancy output, contents not cleared on reset.
// Latency: pop data registered, valid one cycle after the pop; level follows push/pop by one cycle.
// Backpressure: push ignored when full, pop ignored when empty; full/empty come from the registered level.
module adc_cap_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             pop_dat,
    output logic                     pop_vld,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_ONE = 1;
    localparam logic [AW-1:0] PTR_ONE = 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage has no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            pop_dat <= '0;
            pop_vld <= 1'b0;
        end else begin
            pop_vld <= do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                pop_dat <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end
endmodule

// Purpose: arm on i_start, capture i_cap_len offset-binary samples as signed values, drop and count when full.
// Latency: accepted sample visible in o_level next cycle; pop data/valid one cycle after i_rd_en.
// Backpressure: s_axis_tready only in RUN with FIFO not full; tvalid while full in RUN is dropped and counted.
module adc_axis_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int CAP_LEN_W  = 16,
    parameter int OVF_W      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [31:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          i_start,
    input  logic [CAP_LEN_W-1:0]          i_cap_len,
    input  logic                          i_rd_en,
    output logic [23:0]                   o_rd_data,
    output logic                          o_rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy,
    output logic [OVF_W-1:0]              o_ovf_cnt,
    output logic [23:0]                   o_min,
    output logic [23:0]                   o_max
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CAP_LEN_W-1:0]   remaining;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   accept;
    logic                   drop;
    logic                   arm;
    logic signed [23:0]     sample;
    logic [7:0]             unused_tdata_hi;

    assign unused_tdata_hi = s_axis_tdata[31:24];

    // Offset-binary to two's complement is a flip of the top bit.
    assign sample        = {~s_axis_tdata[23], s_axis_tdata[22:0]};
    assign s_axis_tready = (state == RUN) & ~fifo_full;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign drop          = (state == RUN) & fifo_full & s_axis_tvalid;
    assign arm           = (state == IDLE) & i_start;
    assign o_busy        = (state != IDLE);

    adc_cap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (24)
    ) u_fifo (
        .clk      (i_clk),
        .rst_n    (i_rst),
        .push     (accept),
        .push_dat (sample),
        .pop      (i_rd_en),
        .pop_dat  (o_rd_data),
        .pop_vld  (o_rd_valid),
        .level    (o_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = RUN;
            RUN:  if (accept && remaining == CAP_LEN_W'(1)) state_nxt = HOLD;
            HOLD: if (fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            remaining <= '0;
            o_ovf_cnt <= '0;
        end else if (arm) begin
            remaining <= (i_cap_len == '0) ? CAP_LEN_W'(1) : i_cap_len;
            o_ovf_cnt <= '0;
        end else begin
            if (accept) begin
                remaining <= remaining - CAP_LEN_W'(1);
            end
            if (drop && o_ovf_cnt != '1) begin
                o_ovf_cnt <= o_ovf_cnt + OVF_W'(1);
            end
        end
    end

`ifdef ADC_CAP_STATS_EN
    logic               stats_vld;
    logic signed [23:0] min_q;
    logic signed [23:0] max_q;

    // The first sample of a capture seeds both trackers; earlier values hold until then.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            stats_vld <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
        end else if (arm) begin
            stats_vld <= 1'b0;
        end else if (accept) begin
            stats_vld <= 1'b1;
            if (!stats_vld || sample < min_q) min_q <= sample;
            if (!stats_vld || sample > max_q) max_q <= sample;
        end
    end

    assign o_min = min_q;
    assign o_max = max_q;
`else
    assign o_min = '0;
    assign o_max = '0;
`endif
endmodule

// File: tb/tb_adc_axis_capture.sv
// Bench for adc_axis_capture: directed scenarios plus random traffic, scored against a queue-based model.
module tb_adc_axis_capture;
    localparam int DEPTH   = 16;
    localparam int CLW     = 16;
    localparam int OW      = 16;
    localparam int OVF_MAX = (1 << OW) - 1;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HOLD  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       tdata;
    logic              tvalid;
    logic              tready;
    logic              start;
    logic [CLW-1:0]    cap_len;
    logic              rd_en;
    logic [23:0]       rd_data;
    logic              rd_valid;
    logic [4:0]        level;
    logic              busy;
    logic [OW-1:0]     ovf_cnt;
    logic [23:0]       min_v;
    logic [23:0]       max_v;

    int total = 0;
    int bad   = 0;

    // Reference model: phase, sample queue, counters, stats as plain integers.
    int          m_phase;
    logic [23:0] m_q[$];
    int          m_rem;
    int          m_ovf;
    int          m_min;
    int          m_max;
    bit          m_seen;
    logic [23:0] m_rd_data;
    bit          m_rd_valid;

    always #5 clk = ~clk;

    adc_axis_capture #(
        .FIFO_DEPTH (DEPTH),
        .CAP_LEN_W  (CLW),
        .OVF_W      (OW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .i_start       (start),
        .i_cap_len     (cap_len),
        .i_rd_en       (rd_en),
        .o_rd_data     (rd_data),
        .o_rd_valid    (rd_valid),
        .o_level       (level),
        .o_busy        (busy),
        .o_ovf_cnt     (ovf_cnt),
        .o_min         (min_v),
        .o_max         (max_v)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input logic [31:0] t);
        return int'(t[23:0]) - 8388608;
    endfunction

    function automatic logic [23:0] as24(input int v);
        logic [31:0] u;
        u = v;
        return u[23:0];
    endfunction

    task automatic model_reset();
        m_phase    = M_IDLE;
        m_q.delete();
        m_rem      = 0;
        m_ovf      = 0;
        m_min      = 0;
        m_max      = 0;
        m_seen     = 0;
        m_rd_data  = '0;
        m_rd_valid = 0;
    endtask

    // One clock: check ready, advance the model with the current inputs, then check registered outputs.
    task automatic cycle();
        int n;
        int nxt;
        int v;
        bit is_full;
        bit acc;
        n       = m_q.size();
        is_full = (n == DEPTH);
        check("tready", {31'd0, tready}, {31'd0, (m_phase == M_RUN) && !is_full});
        if (!rst) begin
            model_reset();
        end else begin
            nxt = m_phase;
            acc = (m_phase == M_RUN) && !is_full && tvalid;
            m_rd_valid = rd_en && (n > 0);
            if (m_rd_valid) m_rd_data = m_q.pop_front();
            if ((m_phase == M_RUN) && is_full && tvalid && m_ovf < OVF_MAX) m_ovf++;
            if (acc) begin
                v = to_signed(tdata);
                m_q.push_back(as24(v));
                if (!m_seen || v < m_min) m_min = v;
                if (!m_seen || v > m_max) m_max = v;
                m_seen = 1;
                m_rem--;
                if (m_rem == 0) nxt = M_HOLD;
            end
            if (m_phase == M_IDLE && start) begin
                nxt    = M_RUN;
                m_rem  = (cap_len == 0) ? 1 : int'(cap_len);
                m_ovf  = 0;
                m_seen = 0;
            end
            if (m_phase == M_HOLD && n == 0) nxt = M_IDLE;
            m_phase = nxt;
        end
        @(posedge clk);
        #1;
        check("level", {27'd0, level}, m_q.size());
        check("busy", {31'd0, busy}, {31'd0, m_phase != M_IDLE});
        check("ovf_cnt", {16'd0, ovf_cnt}, m_ovf);
        check("rd_valid", {31'd0, rd_valid}, {31'd0, m_rd_valid});
        check("rd_data", {8'd0, rd_data}, {8'd0, m_rd_data});
`ifdef ADC_CAP_STATS_EN
        check("min", {8'd0, min_v}, {8'd0, as24(m_min)});
        check("max", {8'd0, max_v}, {8'd0, as24(m_max)});
`else
        check("min", {8'd0, min_v}, 32'd0);
        check("max", {8'd0, max_v}, 32'd0);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic arm(input int len);
        start   = 1'b1;
        cap_len = CLW'(len);
        cycle();
        start   = 1'b0;
    endtask

    task automatic drain();
        tvalid = 1'b0;
        rd_en  = 1'b1;
        run(DEPTH + 4);
        rd_en  = 1'b0;
        run(2);
    endtask

    logic [31:0] t1_in  [4];
    logic [23:0] t1_exp [4];

    initial begin
        t1_in[0] = 32'h0080_0000; t1_exp[0] = 24'h000000;
        t1_in[1] = 32'hAB80_0010; t1_exp[1] = 24'h000010;
        t1_in[2] = 32'h007F_FFF0; t1_exp[2] = 24'hFFFFF0;
        t1_in[3] = 32'h00FF_FFFF; t1_exp[3] = 24'h7FFFFF;

        rst = 1'b0; tdata = '0; tvalid = 1'b0; start = 1'b0; cap_len = '0; rd_en = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tready", {31'd0, tready}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rd_data", {8'd0, rd_data}, 32'd0);
        check("rst_ovf", {16'd0, ovf_cnt}, 32'd0);
        check("rst_min", {8'd0, min_v}, 32'd0);
        check("rst_max", {8'd0, max_v}, 32'd0);
        rst = 1'b1;
        run(2);

        // Directed capture of four decode corner values.
        arm(4);
        for (int i = 0; i < 4; i++) begin
            tvalid = 1'b1;
            tdata  = t1_in[i];
            cycle();
        end
        tvalid = 1'b0;
        check("t1_hold_busy", {31'd0, busy}, 32'd1);
        check("t1_hold_level", {27'd0, level}, 32'd4);
`ifdef ADC_CAP_STATS_EN
        check("t1_min", {8'd0, min_v}, 32'h00FFFFF0);
        check("t1_max", {8'd0, max_v}, 32'h007FFFFF);
`endif
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            cycle();
            check("t1_pop_data", {8'd0, rd_data}, {8'd0, t1_exp[i]});
            check("t1_pop_valid", {31'd0, rd_valid}, 32'd1);
        end
        rd_en = 1'b0;
        run(2);
        check("t1_idle", {31'd0, busy}, 32'd0);

        // Overflow: more samples than the FIFO holds, no reads.
        arm(20);
        tvalid = 1'b1;
        for (int i = 0; i < 22; i++) begin
            tdata = $urandom;
            cycle();
        end
        check("t2_full_level", {27'd0, level}, 32'd16);
        check("t2_ovf", {16'd0, ovf_cnt}, 32'd6);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdata = $urandom;
            cycle();
        end
        rd_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tdata = $urandom;
            cycle();
        end
        check("t2_hold", {31'd0, busy}, 32'd1);
        check("t2_hold_tready", {31'd0, tready}, 32'd0);
        drain();

        // tvalid while idle is ignored.
        for (int i = 0; i < 10; i++) begin
            tvalid = 1'($urandom_range(0, 1));
            tdata  = $urandom;
            cycle();
        end
        check("t3_level", {27'd0, level}, 32'd0);
        tvalid = 1'b0;

        // Simultaneous push and pop at level 3.
        arm(10);
        tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tdata = $urandom;
            cycle();
        end
        rd_en = 1'b1;
        tdata = $urandom;
        cycle();
        check("t4_level", {27'd0, level}, 32'd3);
        rd_en = 1'b0;
        tvalid = 1'b0;
        run(2);
        tvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tdata = $urandom;
            cycle();
        end
        drain();

        // Reads from an empty FIFO.
        rd_en = 1'b1;
        run(4);
        rd_en = 1'b0;

        // Random traffic across many captures.
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 15) == 0);
            cap_len = CLW'($urandom_range(0, 40));
            tvalid  = 1'($urandom_range(0, 1));
            tdata   = $urandom;
            rd_en   = ($urandom_range(0, 2) != 0);
            cycle();
        end
        start = 1'b0;
        tvalid = 1'b0;
        rd_en = 1'b0;

        // Reset in the middle of a capture, then a zero-length capture.
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        arm(30);
        tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tdata = $urandom;
            cycle();
        end
        tvalid = 1'b0;
        check("t6_level5", {27'd0, level}, 32'd5);
        rst = 1'b0;
        cycle();
        check("t6_level", {27'd0, level}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ovf", {16'd0, ovf_cnt}, 32'd0);
        check("t6_tready", {31'd0, tready}, 32'd0);
        rst = 1'b1;
        arm(0);
        tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdata = $urandom;
            cycle();
        end
        check("t6_one_sample", {27'd0, level}, 32'd1);
        drain();
        check("t6_end_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
